// File: rtl/seq_mul16.sv
// seq_mul16: sequential shift-and-add multiplier that iterates through an external combinational adder.
// Optional signed mode when `define SEQMUL_SIGNED_EN is set (adds input port sgn).
module seq_mul16 #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
`ifdef SEQMUL_SIGNED_EN
  input  logic               sgn,
`endif
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               done_q, done_d;
  logic               last_s;
  logic               shin_s;
  logic [WIDTH-1:0]   add_a_s, add_b_s;
  logic               add_cin_s;

`ifdef SEQMUL_SIGNED_EN
  logic sgn_q, sgn_d;

  // Sign bit of the (WIDTH+1)-bit signed sum acc_hi + add_b + cin.
  function automatic logic signed_shin_f(input logic hi_msb, input logic b_msb, input logic cout);
    signed_shin_f = hi_msb ^ b_msb ^ cout;
  endfunction
`endif

  assign last_s = (cnt_q == LAST_CNT);

  // Adder operand drive: decoded from registers only, quiet outside RUN.
  always_comb begin
    add_a_s   = {WIDTH{1'b0}};
    add_b_s   = {WIDTH{1'b0}};
    add_cin_s = 1'b0;
    if (state_q == S_RUN) begin
      add_a_s = acc_hi_q;
      if (acc_lo_q[0]) begin
`ifdef SEQMUL_SIGNED_EN
        // Negative-weight MSB of a signed multiplier: subtract on the last step.
        if (sgn_q && last_s) begin
          add_b_s   = ~mcand_q;
          add_cin_s = 1'b1;
        end else begin
          add_b_s   = mcand_q;
          add_cin_s = 1'b0;
        end
`else
        add_b_s   = mcand_q;
        add_cin_s = 1'b0;
`endif
      end else begin
        add_b_s   = {WIDTH{1'b0}};
        add_cin_s = 1'b0;
      end
    end else begin
      add_a_s   = {WIDTH{1'b0}};
      add_b_s   = {WIDTH{1'b0}};
      add_cin_s = 1'b0;
    end
  end

  // Bit shifted into the top of the accumulator.
  always_comb begin
`ifdef SEQMUL_SIGNED_EN
    if (sgn_q) begin
      shin_s = signed_shin_f(acc_hi_q[WIDTH-1], add_b_s[WIDTH-1], add_cout);
    end else begin
      shin_s = add_cout;
    end
`else
    shin_s = add_cout;
`endif
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = 1'b0;
`ifdef SEQMUL_SIGNED_EN
    sgn_d     = sgn_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mcand_d  = a;
          acc_lo_d = b;
          acc_hi_d = {WIDTH{1'b0}};
          cnt_d    = {CW{1'b0}};
`ifdef SEQMUL_SIGNED_EN
          sgn_d    = sgn;
`endif
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        {acc_hi_d, acc_lo_d} = {shin_s, add_sum, acc_lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (last_s) begin
          product_d = {shin_s, add_sum, acc_lo_q[WIDTH-1:1]};
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          state_d   = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mcand_q   <= {WIDTH{1'b0}};
      acc_hi_q  <= {WIDTH{1'b0}};
      acc_lo_q  <= {WIDTH{1'b0}};
      cnt_q     <= {CW{1'b0}};
      product_q <= {(2*WIDTH){1'b0}};
      done_q    <= 1'b0;
`ifdef SEQMUL_SIGNED_EN
      sgn_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
`ifdef SEQMUL_SIGNED_EN
      sgn_q     <= sgn_d;
`endif
    end
  end

  assign busy    = (state_q == S_RUN);
  assign done    = done_q;
  assign product = product_q;
  assign add_a   = add_a_s;
  assign add_b   = add_b_s;
  assign add_cin = add_cin_s;

endmodule

// File: doc/seq_mul16.md
# seq_mul16

Sequential shift-and-add multiplier that sits directly upstream of the datapath's 16-bit carry-skip adder. It drives the adder's operand and carry-in inputs each cycle and consumes its sum and carry-out. It produces a 32-bit product from two 16-bit operands over WIDTH iterations, using a start/busy/done handshake. It is used by the MIPS mult/multu path.

## Interface
- WIDTH, 16, operand width; must equal the width of the attached adder.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only when busy=0.
- a  in  WIDTH  multiplicand, latched on the accepting edge.
- b  in  WIDTH  multiplier, latched on the accepting edge.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse; product is valid from this cycle on.
- product  out  2*WIDTH  result register; holds until the next accepted start.
- add_a  out  WIDTH  adder operand A = acc_hi.
- add_b  out  WIDTH  adder operand B = mcand when the current multiplier bit is 1, else 0.
- add_cin  out  1  adder carry-in.
- add_sum  in  WIDTH  adder sum.
- add_cout  in  1  adder carry-out.

## Operation
- Registers:
  - mcand[WIDTH]
  - acc_hi[WIDTH]
  - acc_lo[WIDTH], which holds the multiplier and shifts out right
  - cnt[log2(WIDTH)+1]
  - state
  - product
  - done
- States: IDLE, RUN, DONE.
- IDLE: busy=0.
  - With start=1: mcand<=a, acc_lo<=b, acc_hi<=0, cnt<=0, then go to RUN.
- RUN: busy=1. Each edge performs {acc_hi, acc_lo} <= {shin, add_sum, acc_lo[WIDTH-1:1]}, where:
  - the adder sees add_a=acc_hi;
  - add_b = acc_lo[0] ? mcand : 0;
  - add_cin=0;
  - shin=add_cout when unsigned.
- RUN also does cnt<=cnt+1. On the edge where cnt==WIDTH-1:
  - product <= the post-shift {acc_hi, acc_lo};
  - done <= 1;
  - state goes to DONE.
- DONE: done=1, busy=0; the block returns to IDLE on the next edge.
  - start=1 in DONE is accepted exactly as in IDLE; this supports back-to-back operation.
- start while busy=1 is ignored. No queuing; the latched operands are unchanged.
- a and b may change freely after the accepting edge.
- Arithmetic: the full 2*WIDTH unsigned product. Overflow is impossible, and no truncation occurs.
- Adder outputs are used combinationally in the same cycle. The adder is purely combinational.
- Reset (asserted at any time, including mid-RUN):
  - state=IDLE;
  - all registers cleared to 0;
  - busy=0, done=0, product=0, add_a=0, add_b=0, add_cin=0;
  - the in-flight operation is abandoned with no done pulse.

## Timing
- Let edge E0 be the edge that samples start=1 in IDLE/DONE. busy rises after E0.
- Iterations occur on edges E1..EWIDTH.
- product and done update on edge EWIDTH. done is high for exactly one cycle, and busy is low in that cycle.
- Latency: start to done = WIDTH+1 edges counting E0; 17 for WIDTH=16.
- Throughput: one multiply per WIDTH+1 cycles with back-to-back starts.
- The combinational path per cycle is acc/mcand register → adder → acc register. This is the critical path and the reason the carry-skip adder is used.
- add_* outputs are functions of registers only. No input-to-output combinational path exists except add_sum/add_cout → next state.

## Configuration
- SEQMUL_SIGNED_EN, when defined:
  - adds input port sgn (1 bit), which is latched with the operands.
  - When sgn=1, operands are two's complement.
  - shin = acc_hi[WIDTH-1] ^ add_b[WIDTH-1] ^ add_cout, which gives the correct sign extension.
  - On the final iteration, if acc_lo[0]=1, the block subtracts instead of adding: add_b = ~mcand, add_cin=1.
  - When sgn=0, behaviour is identical to unsigned.
- When SEQMUL_SIGNED_EN is undefined:
  - port sgn is absent;
  - only unsigned multiplication is performed;
  - add_cin is tied to 0.

## Test plan
- a=0x0003, b=0x0005, start for 1 cycle → busy high for 16 cycles, done pulse on the 17th edge, product=0x0000000F, then held.
- a=0xFFFF, b=0xFFFF → product=0xFFFE0001; a=0x1234, b=0x0000 → product=0x00000000 with the same latency.
- Assert start with a=0x0002, b=0x0002, then at cycle 5 assert start with a=0x00FF, b=0x00FF → second start ignored, product=0x00000004.
- Assert rst_n low at cycle 8 of a RUN, release, then start a=7, b=9 → no done from the aborted op, all outputs 0 during reset, next product=0x0000003F.
- Hold start=1 continuously with new operands presented in each DONE cycle → one done every 17 cycles, each product correct for the operands sampled at its E0.
- With SEQMUL_SIGNED_EN and sgn=1:
  - a=0xFFFF, b=0xFFFF → product=0x00000001;
  - a=0x8000, b=0x0002 → product=0xFFFF0000.
